// File: rtl/cfg_bit_loader.sv
// Control-stream writer for the bit-extraction order table: config packets addressed
// to this block update a shadow table that is published atomically; all other packets pass through.
module cfg_bit_loader #(
  parameter int unsigned C_AXIS_DATA_WIDTH = 256,
  parameter int unsigned CFG_ORDER_NUM     = 128,
  parameter int unsigned CFG_S_ORDER_WID   = 16,
  parameter logic [7:0]  MODULE_ID         = 8'h03,
  parameter logic [7:0]  CFG_TYPE          = 8'hB1
) (
  input  logic                                       axis_clk,
  input  logic                                       aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]             s_axis_tkeep,
  input  logic                                       s_axis_tvalid,
  input  logic                                       s_axis_tlast,
  output logic                                       s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic                                       m_axis_tvalid,
  output logic                                       m_axis_tlast,
  input  logic                                       m_axis_tready,
  output logic [CFG_ORDER_NUM*CFG_S_ORDER_WID-1:0]   o_cfg_bit_info,
  output logic                                       o_cfg_bit_updata,
  output logic                                       o_cfg_err
);

  localparam int unsigned ORD_PER_BEAT = C_AXIS_DATA_WIDTH / CFG_S_ORDER_WID;
  localparam int unsigned OFF_W        = $clog2(ORD_PER_BEAT);
  localparam int unsigned CNT_W        = 9;
  localparam int unsigned CNT_MAX      = (1 << CNT_W) - 1;
  localparam int unsigned IDX_W        = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FWD    = 2'd1,
    ST_CFG    = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  typedef logic [CFG_ORDER_NUM-1:0][CFG_S_ORDER_WID-1:0] table_t;

  state_t state_q, state_d;

  logic [7:0]       s_q;
  logic [7:0]       n_q;
  logic [CNT_W-1:0] base_q;
  logic [CNT_W-1:0] written_q;
  logic             dropped_q;
  table_t           shadow_q;
  table_t           info_q;
  logic             upd_q;
  logic             err_q;

  logic             hdr_match_c;
  logic             hdr_take_c;
  logic             hdr_single_err_c;
  logic             cfg_fire_c;
  logic             cfg_end_c;
  logic [CNT_W-1:0] wr_inc_c;
  logic             drop_c;
  logic [CNT_W-1:0] wr_total_c;
  logic             err_total_c;
  logic             commit_ok_c;
  logic             commit_bad_c;
  table_t           shadow_wr_c;
  logic [ORD_PER_BEAT-1:0][CFG_S_ORDER_WID-1:0] ord_c;

  assign hdr_match_c = (s_axis_tdata[7:0] == CFG_TYPE) && (s_axis_tdata[15:8] == MODULE_ID);
  assign ord_c       = s_axis_tdata;

  // Forwarded beats are an unmodified view of the input stream
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tkeep = s_axis_tkeep;
  assign m_axis_tlast = s_axis_tlast;

  always_ff @(posedge axis_clk) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake steering
  always_comb begin
    state_d          = state_q;
    s_axis_tready    = 1'b0;
    m_axis_tvalid    = 1'b0;
    hdr_take_c       = 1'b0;
    hdr_single_err_c = 1'b0;
    cfg_fire_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid && hdr_match_c) begin
          s_axis_tready = 1'b1;
          if (s_axis_tlast) begin
            hdr_single_err_c = 1'b1;
          end else begin
            hdr_take_c = 1'b1;
            state_d    = ST_CFG;
          end
        end else begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
          if (s_axis_tvalid && m_axis_tready && !s_axis_tlast) state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_d = ST_IDLE;
      end
      ST_CFG: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          cfg_fire_c = 1'b1;
          if (s_axis_tlast) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Per-beat accounting: orders that land in the table vs. orders that fall off its end
  always_comb begin
    wr_inc_c = '0;
    drop_c   = 1'b0;
    for (int j = 0; j < ORD_PER_BEAT; j++) begin
      if (IDX_W'(base_q) + IDX_W'(j) < IDX_W'(n_q)) begin
        if (IDX_W'(s_q) + IDX_W'(base_q) + IDX_W'(j) < IDX_W'(CFG_ORDER_NUM))
          wr_inc_c = wr_inc_c + CNT_W'(1);
        else
          drop_c = 1'b1;
      end
    end
  end

  // Entry e takes payload order k = e - S when k falls in this beat and below N
  always_comb begin
    logic [IDX_W-1:0] ke;
    ke          = '0;
    shadow_wr_c = shadow_q;
    for (int e = 0; e < CFG_ORDER_NUM; e++) begin
      ke = IDX_W'(e) - IDX_W'(s_q);
      if ((IDX_W'(e) >= IDX_W'(s_q)) &&
          (ke >= IDX_W'(base_q)) &&
          (ke < IDX_W'(base_q) + IDX_W'(ORD_PER_BEAT)) &&
          (ke < IDX_W'(n_q)))
        shadow_wr_c[e] = ord_c[OFF_W'(ke - IDX_W'(base_q))];
    end
  end

  assign cfg_end_c    = cfg_fire_c && s_axis_tlast;
  assign wr_total_c   = written_q + wr_inc_c;
  assign err_total_c  = dropped_q || drop_c;
  assign commit_ok_c  = cfg_end_c && (wr_total_c == CNT_W'(n_q)) && (n_q != 8'd0) && !err_total_c;
  assign commit_bad_c = cfg_end_c && !commit_ok_c;

  // Packet bookkeeping, shadow table and published table
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      s_q       <= '0;
      n_q       <= '0;
      base_q    <= '0;
      written_q <= '0;
      dropped_q <= 1'b0;
      shadow_q  <= '0;
      info_q    <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      upd_q <= commit_ok_c;
      err_q <= commit_bad_c || hdr_single_err_c;

      if (hdr_take_c) begin
        s_q       <= s_axis_tdata[23:16];
        n_q       <= s_axis_tdata[31:24];
        base_q    <= '0;
        written_q <= '0;
        dropped_q <= 1'b0;
      end else if (cfg_fire_c) begin
        // Saturate so an overlong packet cannot wrap back onto live indices
        if (base_q > CNT_W'(CNT_MAX - ORD_PER_BEAT)) base_q <= CNT_W'(CNT_MAX);
        else                                         base_q <= base_q + CNT_W'(ORD_PER_BEAT);
        written_q <= wr_total_c;
        dropped_q <= err_total_c;
      end

      if (commit_ok_c) begin
        shadow_q <= shadow_wr_c;
        info_q   <= shadow_wr_c;
      end else if (commit_bad_c) begin
        shadow_q <= info_q;
      end else if (cfg_fire_c) begin
        shadow_q <= shadow_wr_c;
      end
    end
  end

  assign o_cfg_bit_info   = info_q;
  assign o_cfg_bit_updata = upd_q;
  assign o_cfg_err        = err_q;

endmodule

// File: tb/tb_cfg_bit_loader.sv
// Directed bench for cfg_bit_loader: a packet-level model predicts the table, pulses and
// forwarded beats; a monitor compares the DUT against it every cycle.
module tb_cfg_bit_loader;

  localparam int unsigned ORD = 128;

  logic         axis_clk = 1'b0;
  logic         aresetn;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic [2047:0] o_cfg_bit_info;
  logic         o_cfg_bit_updata;
  logic         o_cfg_err;

  cfg_bit_loader dut (
    .axis_clk         (axis_clk),
    .aresetn          (aresetn),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tready    (s_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tready    (m_axis_tready),
    .o_cfg_bit_info   (o_cfg_bit_info),
    .o_cfg_bit_updata (o_cfg_bit_updata),
    .o_cfg_err        (o_cfg_err)
  );

  always #5 axis_clk = ~axis_clk;

  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            upd_cyc = -1;
  int            err_cyc = -1;
  int            upd_cnt = 0;
  int            err_cnt = 0;
  bit            run_chk = 1'b0;
  logic [15:0]   tbl [ORD];
  logic [15:0]   ord_buf [256];
  logic [255:0]  pk [$];
  logic [288:0]  fwd_exp [$];
  logic [288:0]  fwd_obs [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ent(input int i);
    return o_cfg_bit_info[16*i +: 16];
  endfunction

  // Packet-level model: judge the whole packet once its last beat has been accepted
  task automatic model_pkt();
    logic [255:0] h, b;
    int s, n, got;
    h = pk[0];
    if (h[7:0] == 8'hB1 && h[15:8] == 8'h03) begin
      s   = int'(h[23:16]);
      n   = int'(h[31:24]);
      got = 16 * (pk.size() - 1);
      if (pk.size() > 1 && n > 0 && got >= n && s + n <= ORD) begin
        for (int k = 0; k < n; k++) begin
          b = pk[1 + k / 16];
          tbl[s + k] = b[16 * (k % 16) +: 16];
        end
        upd_cyc = cyc + 1;
      end else begin
        err_cyc = cyc + 1;
      end
    end
  endtask

  task automatic model_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
    logic [255:0] h;
    pk.push_back(d);
    h = pk[0];
    if (!(h[7:0] == 8'hB1 && h[15:8] == 8'h03)) fwd_exp.push_back({l, k, d});
    if (l) begin
      model_pkt();
      pk.delete();
    end
  endtask

  task automatic monitor();
    logic [2047:0] ev;
    int bad;
    forever begin
      @(negedge axis_clk);
      cyc++;
      if (run_chk) begin
        for (int i = 0; i < ORD; i++) ev[16*i +: 16] = tbl[i];
        n_chk++;
        if (o_cfg_bit_info !== ev) begin
          n_fail++;
          bad = 0;
          for (int i = ORD - 1; i >= 0; i--) if (o_cfg_bit_info[16*i +: 16] !== ev[16*i +: 16]) bad = i;
          $display("FAIL table cycle %0d entry %0d: got %h expected %h", cyc, bad,
                   o_cfg_bit_info[16*bad +: 16], ev[16*bad +: 16]);
        end
        chk("updata pulse", 64'(o_cfg_bit_updata), 64'(cyc == upd_cyc));
        chk("err pulse", 64'(o_cfg_err), 64'(cyc == err_cyc));
        if (o_cfg_bit_updata) upd_cnt++;
        if (o_cfg_err) err_cnt++;
        if (m_axis_tvalid && m_axis_tready) fwd_obs.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge axis_clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l,
                           input bit tgl, output int stalls);
    bit acc;
    acc    = 1'b0;
    stalls = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 40 && !acc; t++) begin
      if (tgl) m_axis_tready = ~m_axis_tready;
      @(negedge axis_clk);
      acc = s_axis_tready;
      @(posedge axis_clk);
      #1;
      if (!acc) stalls++;
    end
    s_axis_tvalid = 1'b0;
    if (!acc) chk("accept timeout", 64'(0), 64'(1));
    else      model_beat(d, k, l);
  endtask

  task automatic send_cfg(input logic [7:0] s, input logic [7:0] n, input int nb, output int st);
    logic [255:0] h, d;
    int tmp;
    h          = '0;
    h[31:0]    = {n, s, 8'h03, 8'hB1};
    h[255:224] = 32'hFEED_F00D;
    send_beat(h, '1, nb == 0, 1'b0, st);
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 16; j++) d[16*j +: 16] = ord_buf[16*b + j];
      send_beat(d, '1, b == nb - 1, 1'b0, tmp);
    end
  endtask

  initial begin
    int st, u0, e0;
    logic [255:0] d;
    logic [288:0] o;
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < ORD; i++) tbl[i] = '0;
    fork
      monitor();
    join_none

    idle(3);
    chk("reset updata", 64'(o_cfg_bit_updata), 64'(0));
    chk("reset err", 64'(o_cfg_err), 64'(0));
    chk("reset m_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("reset bus low", o_cfg_bit_info[63:0], 64'(0));
    aresetn = 1'b1;
    run_chk = 1'b1;
    idle(2);

    // Full-table load
    u0 = upd_cnt;
    for (int i = 0; i < 256; i++) ord_buf[i] = 16'h1000 + 16'(i);
    send_cfg(8'd0, 8'd128, 8, st);
    idle(3);
    chk("t1 entry0", 64'(ent(0)), 64'h1000);
    chk("t1 entry127", 64'(o_cfg_bit_info[2047:2032]), 64'h107F);
    chk("t1 pulses", 64'(upd_cnt - u0), 64'(1));

    // Partial update
    u0 = upd_cnt;
    for (int i = 0; i < 256; i++) ord_buf[i] = 16'hEEEE;
    ord_buf[0] = 16'hAAAA; ord_buf[1] = 16'hBBBB; ord_buf[2] = 16'hCCCC;
    send_cfg(8'd5, 8'd3, 1, st);
    idle(3);
    chk("t2 entry4", 64'(ent(4)), 64'h1004);
    chk("t2 entry5", 64'(ent(5)), 64'hAAAA);
    chk("t2 entry7", 64'(ent(7)), 64'hCCCC);
    chk("t2 entry8", 64'(ent(8)), 64'h1008);
    chk("t2 pulses", 64'(upd_cnt - u0), 64'(1));

    // Foreign packet under downstream backpressure
    u0 = upd_cnt; e0 = err_cnt;
    d = {224'h0123_4567_89AB_CDEF, 8'd2, 8'd0, 8'h04, 8'hB1};
    send_beat(d, 32'hFFFF_FFFF, 1'b0, 1'b1, st);
    d = {8{32'hDEAD_BEEF}};
    send_beat(d, 32'h0000_FFFF, 1'b0, 1'b1, st);
    d = {8{32'h5A5A_C3C3}};
    send_beat(d, 32'h0000_000F, 1'b1, 1'b1, st);
    m_axis_tready = 1'b1;
    idle(3);
    chk("t3 fwd beats", 64'(fwd_obs.size()), 64'(3));
    if (fwd_obs.size() == 3) begin
      o = fwd_obs[2];
      chk("t3 last keep", 64'(o[287:256]), 64'h0000_000F);
      chk("t3 last tlast", 64'(o[288]), 64'(1));
    end
    chk("t3 no updata", 64'(upd_cnt - u0), 64'(0));
    chk("t3 no err", 64'(err_cnt - e0), 64'(0));

    // Write running off the end of the table
    u0 = upd_cnt; e0 = err_cnt;
    for (int i = 0; i < 256; i++) ord_buf[i] = 16'h3000 + 16'(i);
    send_cfg(8'd120, 8'd16, 1, st);
    idle(3);
    chk("t4 err", 64'(err_cnt - e0), 64'(1));
    chk("t4 no updata", 64'(upd_cnt - u0), 64'(0));
    chk("t4 entry120", 64'(ent(120)), 64'h1078);

    // Short packet, then a one-order commit
    e0 = err_cnt;
    for (int i = 0; i < 256; i++) ord_buf[i] = 16'h9000 + 16'(i);
    send_cfg(8'd0, 8'd20, 1, st);
    idle(3);
    chk("t5 err", 64'(err_cnt - e0), 64'(1));
    chk("t5 entry0 kept", 64'(ent(0)), 64'h1000);
    for (int i = 0; i < 256; i++) ord_buf[i] = 16'h7777;
    ord_buf[0] = 16'h5555;
    send_cfg(8'd0, 8'd1, 1, st);
    idle(3);
    chk("t5 entry0", 64'(ent(0)), 64'h5555);
    chk("t5 entry1", 64'(ent(1)), 64'h1001);

    // N == 0 and header-only packets
    e0 = err_cnt;
    send_cfg(8'd0, 8'd0, 1, st);
    idle(2);
    send_cfg(8'd3, 8'd2, 0, st);
    idle(3);
    chk("t6 errs", 64'(err_cnt - e0), 64'(2));

    // Config packet immediately followed by a foreign packet
    ord_buf[0] = 16'hAB01; ord_buf[1] = 16'hAB02;
    send_cfg(8'd10, 8'd2, 1, st);
    d = {224'hCAFE, 8'd0, 8'd0, 8'h03, 8'h22};
    send_beat(d, 32'h00FF_00FF, 1'b0, 1'b0, st);
    chk("t7 commit stall", 64'(st), 64'(1));
    d = {8{32'h1357_9BDF}};
    send_beat(d, 32'hFFFF_0000, 1'b1, 1'b0, st);
    chk("t7 no stall", 64'(st), 64'(0));
    idle(3);
    chk("t7 entry10", 64'(ent(10)), 64'hAB01);
    chk("t7 entry11", 64'(ent(11)), 64'hAB02);

    // Forwarded stream against the model
    chk("fwd total", 64'(fwd_obs.size()), 64'(5));
    chk("fwd vs model", 64'(fwd_obs.size()), 64'(fwd_exp.size()));
    for (int i = 0; i < fwd_obs.size() && i < fwd_exp.size(); i++) begin
      n_chk++;
      if (fwd_obs[i] !== fwd_exp[i]) begin
        n_fail++;
        $display("FAIL fwd beat %0d: got %h expected %h", i, fwd_obs[i], fwd_exp[i]);
      end
    end

    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
